// File: rtl/serial_frame_deserializer_pkg.sv
// Shared types and defaults for the serial frame deserializer.
package sfd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      DONE = 2'd3
   } sfd_state_e;

   localparam int ADDR_W_DEF = 2;
   localparam int DATA_W_DEF = 8;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/serial_frame_deserializer_bit_counter.sv
// Bit counter for the deserializer: clear has priority over increment,
// tc flags that the current count equals the runtime limit.
module bit_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   input  logic [W-1:0] limit,
   output logic [W-1:0] cnt,
   output logic         tc
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: clear wins, otherwise step on accepted bits.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Count register, asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;
   assign tc  = (cnt_q == limit);

endmodule

// File: rtl/serial_frame_deserializer.sv
// Serial frame deserializer: collects ADDR_W index bits then DATA_W payload
// bits (both MSB first) from a gated serial stream and presents them in
// parallel with a one-clock ParValid pulse; early window close pulses FrameErr.
module serial_frame_deserializer
   import sfd_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              Clk_EN,
   input  logic              SerIn,
   input  logic              SerInValid,
   output logic [ADDR_W-1:0] ChanSel,
   output logic [DATA_W-1:0] ParOut,
   output logic              ParValid,
   output logic              FrameErr,
   output logic              Busy
);

   localparam int CW = $clog2(max_int(ADDR_W, DATA_W) + 1);
   // tc fires on the count reached just before the last bit of a field,
   // so the field's final bit is recognised on the edge that samples it.
   localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_W - 1);
   localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);

   sfd_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_sr_q, addr_sr_d;
   logic [DATA_W-1:0] data_sr_q, data_sr_d;
   logic [ADDR_W-1:0] chan_sel_q, chan_sel_d;
   logic [DATA_W-1:0] par_out_q, par_out_d;
   logic              par_valid_q, par_valid_d;
   logic              frame_err_q, frame_err_d;
   logic              busy_q, busy_d;

   logic              cnt_clr;
   logic              cnt_inc;
   logic [CW-1:0]     cnt_limit;
   logic [CW-1:0]     cnt;
   logic              cnt_tc;
   logic [ADDR_W-1:0] addr_shift;
   logic [DATA_W-1:0] data_shift;

   assign addr_shift = (addr_sr_q << 1) | ADDR_W'(SerIn);
   assign data_shift = (data_sr_q << 1) | DATA_W'(SerIn);

   bit_counter #(.W(CW)) u_bit_counter (
      .clk   (clk),
      .rst   (rst),
      .clr   (cnt_clr),
      .inc   (cnt_inc),
      .limit (cnt_limit),
      .cnt   (cnt),
      .tc    (cnt_tc)
   );

   // Next-state, shift and output logic; pulses default low every clock.
   always_comb begin
      state_d     = state_q;
      addr_sr_d   = addr_sr_q;
      data_sr_d   = data_sr_q;
      chan_sel_d  = chan_sel_q;
      par_out_d   = par_out_q;
      par_valid_d = 1'b0;
      frame_err_d = 1'b0;
      cnt_clr     = 1'b0;
      cnt_inc     = 1'b0;
      cnt_limit   = ADDR_LAST;
      case (state_q)
         IDLE: begin
            if (Clk_EN && SerInValid) begin
               addr_sr_d = addr_shift;
               if (ADDR_W == 1) begin
                  cnt_clr = 1'b1;
                  state_d = DATA;
               end else begin
                  cnt_inc = 1'b1;
                  state_d = ADDR;
               end
            end
         end
         ADDR: begin
            cnt_limit = ADDR_LAST;
            if (Clk_EN) begin
               if (!SerInValid) begin
                  frame_err_d = 1'b1;
                  cnt_clr     = 1'b1;
                  state_d     = IDLE;
               end else begin
                  addr_sr_d = addr_shift;
                  if (cnt_tc) begin
                     cnt_clr = 1'b1;
                     state_d = DATA;
                  end else begin
                     cnt_inc = 1'b1;
                  end
               end
            end
         end
         DATA: begin
            cnt_limit = DATA_LAST;
            if (Clk_EN) begin
               if (!SerInValid) begin
                  frame_err_d = 1'b1;
                  cnt_clr     = 1'b1;
                  state_d     = IDLE;
               end else begin
                  data_sr_d = data_shift;
                  if (cnt_tc) begin
                     chan_sel_d  = addr_sr_q;
                     par_out_d   = data_shift;
                     par_valid_d = 1'b1;
                     cnt_clr     = 1'b1;
                     state_d     = DONE;
                  end else begin
                     cnt_inc = 1'b1;
                  end
               end
            end
         end
         DONE: begin
            if (Clk_EN && !SerInValid) begin
               state_d = IDLE;
            end
         end
         default: begin
            cnt_clr = 1'b1;
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d == ADDR) || (state_d == DATA);
   end

   // State, shift and output registers, asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         addr_sr_q   <= '0;
         data_sr_q   <= '0;
         chan_sel_q  <= '0;
         par_out_q   <= '0;
         par_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_sr_q   <= addr_sr_d;
         data_sr_q   <= data_sr_d;
         chan_sel_q  <= chan_sel_d;
         par_out_q   <= par_out_d;
         par_valid_q <= par_valid_d;
         frame_err_q <= frame_err_d;
         busy_q      <= busy_d;
      end
   end

   assign ChanSel  = chan_sel_q;
   assign ParOut   = par_out_q;
   assign ParValid = par_valid_q;
   assign FrameErr = frame_err_q;
   assign Busy     = busy_q;

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Bench for serial_frame_deserializer (ADDR_W=2, DATA_W=8): directed frames,
// expected events queued by the stimulus, popped by an independent monitor.
module tb_serial_frame_deserializer;

   logic       clk;
   logic       rst;
   logic       Clk_EN;
   logic       SerIn;
   logic       SerInValid;
   logic [1:0] ChanSel;
   logic [7:0] ParOut;
   logic       ParValid;
   logic       FrameErr;
   logic       Busy;

   typedef struct packed {
      logic       is_err;
      logic [1:0] ch;
      logic [7:0] d;
   } exp_t;

   exp_t sb[$];

   int n_tests = 0;
   int n_fail  = 0;
   int m_tests = 0;
   int m_fail  = 0;

   serial_frame_deserializer #(.ADDR_W(2), .DATA_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .Clk_EN     (Clk_EN),
      .SerIn      (SerIn),
      .SerInValid (SerInValid),
      .ChanSel    (ChanSel),
      .ParOut     (ParOut),
      .ParValid   (ParValid),
      .FrameErr   (FrameErr),
      .Busy       (Busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Three disabled clocks, then one enabled clock carrying (b, v).
   task automatic en_cycle(input logic b, input logic v);
      repeat (3) @(negedge clk);
      Clk_EN     = 1'b1;
      SerIn      = b;
      SerInValid = v;
      @(negedge clk);
      Clk_EN = 1'b0;
   endtask

   task automatic send_bits(input logic [15:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) en_cycle(bits[i], 1'b1);
   endtask

   // Whole 10-bit frame; ParValid must be up right after the last sampled edge.
   task automatic send_frame(input string name, input logic [1:0] ch, input logic [7:0] d);
      sb.push_back(exp_t'{1'b0, ch, d});
      send_bits({6'd0, ch, d}, 10);
      chk({name, "_pv_rise"}, ParValid, 1);
      @(negedge clk);
      chk({name, "_pv_fall"}, ParValid, 0);
   endtask

   // Monitor: every ParValid / FrameErr pulse must match the head of the queue.
   always @(negedge clk) begin
      if (ParValid || FrameErr) begin
         m_tests++;
         if (ParValid && FrameErr) begin
            m_fail++;
            $display("FAIL mon_both: ParValid and FrameErr high together");
         end else if (sb.size() == 0) begin
            m_fail++;
            $display("FAIL mon_unexpected: pv=%0b err=%0b with no expected event", ParValid, FrameErr);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (e.is_err) begin
               if (!FrameErr) begin
                  m_fail++;
                  $display("FAIL mon_kind: got ParValid, expected FrameErr");
               end
            end else if (!ParValid) begin
               m_fail++;
               $display("FAIL mon_kind: got FrameErr, expected ParValid ch=%0d d=%0h", e.ch, e.d);
            end else if (ChanSel !== e.ch || ParOut !== e.d) begin
               m_fail++;
               $display("FAIL mon_data: got ch=%0d d=%0h, expected ch=%0d d=%0h",
                        ChanSel, ParOut, e.ch, e.d);
            end
         end
      end
   end

   initial begin
      rst        = 1'b0;
      Clk_EN     = 1'b0;
      SerIn      = 1'b0;
      SerInValid = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_chansel", ChanSel, 0);
      chk("rst_parout", ParOut, 0);
      chk("rst_pv", ParValid, 0);
      chk("rst_err", FrameErr, 0);
      chk("rst_busy", Busy, 0);
      rst = 1'b1;
      @(negedge clk);

      // Good frame: ch=2, 0xA5
      send_frame("good", 2'd2, 8'hA5);
      en_cycle(1'b0, 1'b0);
      chk("good_ch", ChanSel, 2);
      chk("good_d", ParOut, 8'hA5);
      chk("good_busy", Busy, 0);

      // Abort after 5 payload bits
      sb.push_back(exp_t'{1'b1, 2'd0, 8'h00});
      send_bits(16'b01, 2);
      chk("abort_busy_mid", Busy, 1);
      send_bits(16'b11001, 5);
      en_cycle(1'b0, 1'b0);
      chk("abort_err", FrameErr, 1);
      chk("abort_busy", Busy, 0);
      chk("abort_ch_kept", ChanSel, 2);
      chk("abort_d_kept", ParOut, 8'hA5);
      @(negedge clk);
      chk("abort_err_fall", FrameErr, 0);

      // Overlong window: 14 valid bits, only the first 10 count
      send_frame("long", 2'd1, 8'h5A);
      send_bits(16'b1010, 4);
      chk("long_busy_done", Busy, 0);
      en_cycle(1'b0, 1'b0);
      chk("long_ch", ChanSel, 1);
      chk("long_d", ParOut, 8'h5A);

      // Enable gating mid-frame: 3 + 5 payload bits around a toggling gap
      sb.push_back(exp_t'{1'b0, 2'd3, 8'hC3});
      send_bits(16'b11110, 5);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         SerIn      = ~SerIn;
         SerInValid = ~SerInValid;
      end
      chk("gate_busy", Busy, 1);
      chk("gate_ch_hold", ChanSel, 1);
      chk("gate_d_hold", ParOut, 8'h5A);
      send_bits(16'b00011, 5);
      chk("gate_pv", ParValid, 1);
      en_cycle(1'b0, 1'b0);
      chk("gate_ch", ChanSel, 3);
      chk("gate_d", ParOut, 8'hC3);

      // Back-to-back frames with one enabled idle cycle between
      send_frame("b2b1", 2'd3, 8'h3C);
      en_cycle(1'b0, 1'b0);
      send_frame("b2b2", 2'd0, 8'hFF);
      en_cycle(1'b0, 1'b0);
      chk("b2b_ch", ChanSel, 0);
      chk("b2b_d", ParOut, 8'hFF);

      // Asynchronous reset mid-frame, then a clean frame from IDLE
      send_bits(16'b1010, 4);
      chk("mid_busy", Busy, 1);
      #2;
      rst = 1'b0;
      #1;
      chk("midrst_ch", ChanSel, 0);
      chk("midrst_d", ParOut, 0);
      chk("midrst_busy", Busy, 0);
      chk("midrst_err", FrameErr, 0);
      chk("midrst_pv", ParValid, 0);
      @(negedge clk);
      SerInValid = 1'b0;
      rst        = 1'b1;
      @(negedge clk);
      chk("postrst_err", FrameErr, 0);
      send_frame("postrst", 2'd2, 8'h81);
      en_cycle(1'b0, 1'b0);
      chk("postrst_ch", ChanSel, 2);
      chk("postrst_d", ParOut, 8'h81);

      repeat (4) @(negedge clk);
      chk("sb_empty", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests + m_tests, n_fail + m_fail);
      $finish;
   end

endmodule
